// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes seen on
// MDOp and the controller state encoding. The decode stage uses the same
// definitions so both sides agree on MDOp values.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } md_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } mdu_state_t;

  // MULT/MULTU/DIV/DIVU occupy codes 0..3.
  function automatic logic is_iter_op(input logic [2:0] op);
    return ~op[2];
  endfunction

  function automatic logic is_mul_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Multiplication is shift-add, division is restoring; both run one step per
// cycle on a single 2*WIDTH accumulator, working on operand magnitudes with
// the sign fixup applied when HI/LO are written.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; MTHI/MTLO are applied directly here
//   CALC  | WIDTH iteration steps in progress; HI/LO hold, start ignored
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       MDOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH) + 1;

  mdu_state_t         state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [WIDTH-1:0]   a_raw_q;
  logic               neg_lo_q;
  logic               neg_hi_q;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;
  logic               accept_iter;
  logic               accept_mthi;
  logic               accept_mtlo;
  logic               last_iter;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

  assign accept_iter = start && (state == IDLE) && is_iter_op(MDOp);
  assign accept_mthi = start && (state == IDLE) && (MDOp == OP_MTHI);
  assign accept_mtlo = start && (state == IDLE) && (MDOp == OP_MTLO);
  // Counter is loaded with WIDTH and the step taken while it reads 1 is the last.
  assign last_iter   = (state == CALC) && (cnt == CW'(1));
  assign busy        = (state == CALC);

  assign a_neg = is_signed_op(MDOp) & A[WIDTH-1];
  assign b_neg = is_signed_op(MDOp) & B[WIDTH-1];
  assign mag_a = a_neg ? -A : A;
  assign mag_b = b_neg ? -B : B;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: enter CALC on an accepted iterative op, leave after the last step.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_iter) state_nxt = CALC;
      CALC:    if (last_iter)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One iteration step on the shared accumulator. Multiply keeps the
  // multiplier in the low half and shifts the partial product in from the
  // top; divide shifts the dividend out of the low half into the remainder
  // and shifts quotient bits in at the bottom.
  always_comb begin
    acc_step = acc;
    sum      = '0;
    rem_sh   = '0;
    diff     = '0;
    if (is_mul_op(op_q)) begin
      sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd_q} : '0);
      acc_step = {sum, acc[WIDTH-1:1]};
    end else begin
      rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      diff   = rem_sh - {1'b0, opnd_q};
      if (!diff[WIDTH]) acc_step = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else              acc_step = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

  // Sign fixup of the final step result.
  always_comb begin
    prod_fix = neg_lo_q ? -acc_step : acc_step;
    q_fix    = neg_lo_q ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
    r_fix    = neg_hi_q ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
  end

  // Operand capture, iteration, HI/LO writes and the done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      op_q     <= '0;
      opnd_q   <= '0;
      a_raw_q  <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      acc      <= '0;
      done     <= 1'b0;
      HI       <= '0;
      LO       <= '0;
    end else begin
      done <= 1'b0;
      if (accept_iter) begin
        op_q     <= MDOp;
        a_raw_q  <= A;
        cnt      <= CW'(WIDTH);
        neg_lo_q <= a_neg ^ b_neg;
        // Remainder follows the dividend's sign.
        neg_hi_q <= a_neg;
        if (is_mul_op(MDOp)) begin
          opnd_q <= mag_a;
          acc    <= {{WIDTH{1'b0}}, mag_b};
        end else begin
          opnd_q <= mag_b;
          acc    <= {{WIDTH{1'b0}}, mag_a};
        end
      end else if (state == CALC) begin
        acc <= acc_step;
        cnt <= cnt - CW'(1);
        if (last_iter) begin
          done <= 1'b1;
          if (is_mul_op(op_q)) begin
            HI <= prod_fix[2*WIDTH-1:WIDTH];
            LO <= prod_fix[WIDTH-1:0];
          end else if (opnd_q == '0) begin
            // Divide by zero: quotient saturates to all ones, HI returns the dividend.
            HI <= a_raw_q;
            LO <= '1;
          end else begin
            HI <= r_fix;
            LO <= q_fix;
          end
        end
      end
      if (accept_mthi) HI <= A;
      if (accept_mtlo) LO <= A;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit at WIDTH=32 with hand-computed results.
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   MDOp;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W-1:0] HI;
  logic [W-1:0] LO;

  int           n_run  = 0;
  int           n_fail = 0;
  logic [W-1:0] exp_hi;
  logic [W-1:0] exp_lo;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .MDOp  (MDOp),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_run++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, expv);
    end
  endtask

  // Called at a negedge; issues the op and returns at the negedge where done is seen.
  // Optionally pokes a second start (inj_op/inj_a) at step inj_cyc of the calculation.
  task automatic run_iter(input string tag, input logic [2:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ehi, input logic [W-1:0] elo,
                          input int inj_cyc, input logic [2:0] inj_op,
                          input logic [W-1:0] inj_a);
    int   lat;
    logic hold_ok;
    start = 1'b1; MDOp = op; A = a; B = b;
    @(negedge clk);
    start = 1'b0; MDOp = 3'd7; A = ~a; B = ~b;
    check({tag, " busy_start"}, 64'(busy), 64'd1);
    check({tag, " done_start"}, 64'(done), 64'd0);
    lat = 0;
    hold_ok = 1'b1;
    while (!done && lat < 40) begin
      if (HI !== exp_hi || LO !== exp_lo || busy !== 1'b1) hold_ok = 1'b0;
      if (inj_cyc != 0 && lat == inj_cyc) begin
        start = 1'b1; MDOp = inj_op; A = inj_a;
      end
      @(negedge clk);
      start = 1'b0; MDOp = 3'd7;
      lat++;
    end
    check({tag, " hold"},    64'(hold_ok), 64'd1);
    check({tag, " latency"}, 64'(lat),     64'd32);
    check({tag, " done"},    64'(done),    64'd1);
    check({tag, " busy_end"},64'(busy),    64'd0);
    check({tag, " HI"},      64'(HI),      64'(ehi));
    check({tag, " LO"},      64'(LO),      64'(elo));
    exp_hi = ehi;
    exp_lo = elo;
  endtask

  task automatic idle_after(input string tag);
    @(negedge clk);
    check({tag, " done_pulse"}, 64'(done), 64'd0);
    check({tag, " busy_idle"},  64'(busy), 64'd0);
  endtask

  // Single-edge ops (MTHI/MTLO/reserved): no busy, no done.
  task automatic run_direct(input string tag, input logic [2:0] op, input logic [W-1:0] a);
    start = 1'b1; MDOp = op; A = a; B = 32'h5555_5555;
    @(negedge clk);
    start = 1'b0; MDOp = 3'd7;
    if (op == OP_MTHI) exp_hi = a;
    if (op == OP_MTLO) exp_lo = a;
    check({tag, " HI"},   64'(HI),   64'(exp_hi));
    check({tag, " LO"},   64'(LO),   64'(exp_lo));
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " done"}, 64'(done), 64'd0);
    @(negedge clk);
    check({tag, " busy_next"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int dones;
    reset = 1'b1; start = 1'b0; MDOp = '0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst HI",   64'(HI),   64'd0);
    check("rst LO",   64'(LO),   64'd0);
    reset = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    @(negedge clk);

    run_iter("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, 3'd0, '0);
    idle_after("multu_max");
    run_iter("mult_neg",  OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 0, 3'd0, '0);
    idle_after("mult_neg");
    run_iter("mult_pos",  OP_MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 0, 3'd0, '0);
    idle_after("mult_pos");

    // Second op issued in the same cycle that done is high.
    run_iter("div_neg",   OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 3'd0, '0);
    run_iter("divu_zero", OP_DIVU,  32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 0, 3'd0, '0);
    idle_after("divu_zero");

    run_iter("div_negb",  OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 0, 3'd0, '0);
    idle_after("div_negb");
    run_iter("div_ovf",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0, 3'd0, '0);
    idle_after("div_ovf");
    run_iter("divu_big",  OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 0, 3'd0, '0);
    idle_after("divu_big");
    run_iter("div_both",  OP_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, 0, 3'd0, '0);
    idle_after("div_both");

    run_direct("mtlo",  OP_MTLO, 32'h1234_5678);
    run_direct("mthi",  OP_MTHI, 32'h0000_0000);
    run_direct("rsvd6", 3'd6,    32'hDEAD_BEEF);
    run_direct("rsvd7", 3'd7,    32'hCAFE_F00D);

    run_iter("multu_inj", OP_MULTU, 32'h0000_0007, 32'h0000_0006, 32'h0000_0000, 32'h0000_002A, 5, OP_MTHI, 32'hAAAA_AAAA);
    idle_after("multu_inj");

    // Abort a DIV partway through with reset.
    start = 1'b1; MDOp = OP_DIV; A = 32'h0000_1234; B = 32'h0000_0007;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("abort busy_pre", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort busy", 64'(busy), 64'd0);
    check("abort HI",   64'(HI),   64'd0);
    check("abort LO",   64'(LO),   64'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dones++;
      @(negedge clk);
    end
    check("abort no_done", 64'(dones), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
